// File: rtl/instruction_mem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// Stream: 2-byte big-endian word count, then 4 bytes per word, MSB first.
package instr_loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned HDR_BYTES      = 2;
    localparam int unsigned COUNT_W        = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_HI,
        ST_HDR_LO,
        ST_DATA,
        ST_WRITE,
        ST_DONE,
        ST_ERROR
    } state_e;

endpackage

// File: rtl/instruction_mem_loader_packer.sv
// Big-endian byte-to-word packer: shifts bytes in MSB first and counts them.
// word_full flags that the next shift completes a word.
module byte_word_packer
    import instr_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        shift_en,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full
);

    localparam int unsigned CNT_W = $clog2(BYTES_PER_WORD);

    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      shift_q, shift_d;

    always_comb begin
        count_d = count_q;
        shift_d = shift_q;
        if (clear) begin
            count_d = '0;
            shift_d = '0;
        end else if (shift_en) begin
            shift_d = {shift_q[23:0], byte_in};
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            shift_q <= '0;
        end else begin
            count_q <= count_d;
            shift_q <= shift_d;
        end
    end

    assign word      = shift_q;
    assign word_full = (count_q == CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instruction_mem_loader.sv
// Loads a length-prefixed program image from a byte stream into instruction memory,
// one word write per 4 bytes, holding the CPU while the load is in progress.
module instruction_mem_loader
    import instr_loader_pkg::*;
#(
    parameter int unsigned DEPTH     = 128,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        ByteValid,
    input  logic [7:0]  ByteData,
    output logic        ByteReady,
    output logic        MemWrite,
    output logic [31:0] WriteAddress,
    output logic [31:0] WriteData,
    output logic        CpuHold,
    output logic        Done,
    output logic        Error
);

    localparam int unsigned IDX_W = $clog2(DEPTH + 1);

    state_e             state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [COUNT_W-1:0] hdr_n;
    logic [IDX_W-1:0]   index_q, index_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        data_q, data_d;
    logic               byte_ready_q, mem_write_q, cpu_hold_q, done_q, error_q;

    logic               xfer;
    logic               pk_shift, pk_clear, pk_full;
    logic [31:0]        pk_word;

    assign xfer = ByteValid & byte_ready_q;

    byte_word_packer u_packer (
        .clk       (Clk),
        .rst       (Reset),
        .shift_en  (pk_shift),
        .clear     (pk_clear),
        .byte_in   (ByteData),
        .word      (pk_word),
        .word_full (pk_full)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        index_d  = index_q;
        addr_d   = addr_q;
        data_d   = data_q;
        hdr_n    = {count_q[15:8], ByteData};
        pk_shift = 1'b0;
        pk_clear = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_ERROR: if (Start) state_d = ST_HDR_HI;
            ST_HDR_HI: if (xfer) begin
                count_d[15:8] = ByteData;
                state_d       = ST_HDR_LO;
            end
            // Full 16-bit count compare, so N == DEPTH is legal and DEPTH+1 is not.
            ST_HDR_LO: if (xfer) begin
                count_d = hdr_n;
                if (hdr_n == '0) begin
                    state_d = ST_DONE;
                end else if (32'(hdr_n) > DEPTH) begin
                    state_d = ST_ERROR;
                end else begin
                    state_d  = ST_DATA;
                    index_d  = '0;
                    pk_clear = 1'b1;
                end
            end
            ST_DATA: if (xfer) begin
                pk_shift = 1'b1;
                if (pk_full) begin
                    state_d = ST_WRITE;
                    data_d  = {pk_word[23:0], ByteData};
                    addr_d  = BASE_ADDR + (32'(index_q) << 2);
                end
            end
            ST_WRITE: begin
                index_d = index_q + IDX_W'(1);
                if (COUNT_W'(index_q) + COUNT_W'(1) == count_q) state_d = ST_DONE;
                else                                            state_d = ST_DATA;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            index_q      <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            byte_ready_q <= 1'b0;
            mem_write_q  <= 1'b0;
            cpu_hold_q   <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            index_q      <= index_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            byte_ready_q <= (state_d == ST_HDR_HI) || (state_d == ST_HDR_LO) ||
                            (state_d == ST_DATA);
            mem_write_q  <= (state_d == ST_WRITE);
            cpu_hold_q   <= (state_d != ST_IDLE);
            done_q       <= (state_d == ST_DONE);
            error_q      <= (state_d == ST_ERROR);
        end
    end

    assign ByteReady    = byte_ready_q;
    assign MemWrite     = mem_write_q;
    assign WriteAddress = addr_q;
    assign WriteData    = data_q;
    assign CpuHold      = cpu_hold_q;
    assign Done         = done_q;
    assign Error        = error_q;

endmodule
